// File: rtl/ysyx_25020037_issue_ctrl.sv
// Issue controller between decode and EXU.
//
// Decides each cycle whether the decoded instruction may leave decode. A
// per-register pending-write scoreboard blocks RAW/WAW hazards, a global
// in-flight counter caps outstanding work, and a small FSM serializes
// CSR/ecall/mret/fence.i: wait for an empty pipeline, issue, then hold off
// all issue until that instruction retires.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   dec_*               decoded instruction (valid, sources, dest, serial flag)
//   flush               redirect this cycle; blocks issue
//   exu_ready           EXU can accept an instruction
//   retire_*            one retirement per cycle (valid, rd, write-enable)
//   issue_fire          instruction leaves decode this cycle (combinational)
//   dec_stall           dec_valid & ~issue_fire
//   inflight_cnt        registered count of issued-but-not-retired instructions
//   busy_vec            bit i set when xi has a pending write (bit 0 always 0)
//   ctrl_state          0=IDLE, 1=DRAIN, 2=SERIAL
//   err                 sticky: retire with nothing in flight, or retire write
//                       to a register with no pending write

// Pending-write counter for one architectural register.
module ysyx_25020037_issue_ctrl_regcnt #(
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic uflow
);
    logic [CNT_W-1:0] cnt;

    assign busy  = |cnt;
    // Retire write with nothing pending and no concurrent issue to cover it.
    assign uflow = dec & ~inc & ~busy;

    always_ff @(posedge clk) begin
        if (rst)                     cnt <= '0;
        else if (inc & ~dec)         cnt <= cnt + 1'b1;
        else if (dec & ~inc & busy)  cnt <= cnt - 1'b1;
    end
endmodule

module ysyx_25020037_issue_ctrl #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_rs1_en,
    input  logic             dec_rs2_en,
    input  logic [4:0]       dec_rd,
    input  logic             dec_rd_we,
    input  logic             dec_serial,
    input  logic             flush,
    input  logic             exu_ready,
    input  logic             retire_valid,
    input  logic [4:0]       retire_rd,
    input  logic             retire_we,
    output logic             issue_fire,
    output logic             dec_stall,
    output logic [CNT_W-1:0] inflight_cnt,
    output logic [31:0]      busy_vec,
    output logic [1:0]       ctrl_state,
    output logic             err
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SERIAL = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] uflow_vec;
    logic        hz, full, empty, cnt_uflow;

    // ---------------- scoreboard ----------------
    assign busy_vec[0]  = 1'b0;
    assign uflow_vec[0] = 1'b0;

    for (genvar r = 1; r < 32; r++) begin : g_reg
        ysyx_25020037_issue_ctrl_regcnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (issue_fire & dec_rd_we & (dec_rd == 5'(r))),
            .dec   (retire_valid & retire_we & (retire_rd == 5'(r))),
            .busy  (busy_vec[r]),
            .uflow (uflow_vec[r])
        );
    end

    // Registered state only: a same-cycle retire does not clear the hazard.
    assign hz = (dec_rs1_en & busy_vec[dec_rs1]) |
                (dec_rs2_en & busy_vec[dec_rs2]) |
                (dec_rd_we  & busy_vec[dec_rd]);

    assign full      = (inflight_cnt == CNT_W'(MAX_INFLIGHT));
    assign empty     = (inflight_cnt == '0);
    assign cnt_uflow = retire_valid & empty;

    // ---------------- issue FSM ----------------
    always_comb begin
        issue_fire = 1'b0;
        state_nxt  = state;
        case (state)
            IDLE: begin
                if (dec_valid & dec_serial) begin
                    if (empty & exu_ready & ~flush) begin
                        issue_fire = 1'b1;
                        state_nxt  = SERIAL;
                    end else begin
                        state_nxt  = DRAIN;
                    end
                end else begin
                    issue_fire = dec_valid & exu_ready & ~flush & ~hz & ~full;
                end
            end
            DRAIN: begin
                // Decode moved on or got redirected: abandon the drain.
                if (~dec_valid | flush) begin
                    state_nxt = IDLE;
                end else if (empty & exu_ready) begin
                    issue_fire = 1'b1;
                    state_nxt  = SERIAL;
                end
            end
            SERIAL: begin
                if (retire_valid & (inflight_cnt == CNT_W'(1)))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) issue_fire = 1'b0;
    end

    assign dec_stall  = dec_valid & ~issue_fire;
    assign ctrl_state = state;

    // ---------------- state / counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            inflight_cnt <= '0;
            err          <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue_fire & ~retire_valid)
                inflight_cnt <= inflight_cnt + 1'b1;
            else if (retire_valid & ~issue_fire & ~empty)
                inflight_cnt <= inflight_cnt - 1'b1;
            err <= err | cnt_uflow | (|uflow_vec);
        end
    end
endmodule

// File: tb/tb_ysyx_25020037_issue_ctrl.sv
// Directed bench for ysyx_25020037_issue_ctrl with hand-computed expectations.
module tb_ysyx_25020037_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_rs1_en, dec_rs2_en, dec_rd_we, dec_serial;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd, retire_rd;
    logic        flush, exu_ready, retire_valid, retire_we;
    logic        issue_fire, dec_stall, err;
    logic [3:0]  inflight_cnt;
    logic [31:0] busy_vec;
    logic [1:0]  ctrl_state;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    ysyx_25020037_issue_ctrl #(.MAX_INFLIGHT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en),
        .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_serial(dec_serial),
        .flush(flush), .exu_ready(exu_ready),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_we(retire_we),
        .issue_fire(issue_fire), .dec_stall(dec_stall),
        .inflight_cnt(inflight_cnt), .busy_vec(busy_vec),
        .ctrl_state(ctrl_state), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_en = 0; dec_rs2_en = 0;
        dec_rd = 0; dec_rd_we = 0; dec_serial = 0; flush = 0; exu_ready = 1;
        retire_valid = 0; retire_rd = 0; retire_we = 0;
    endtask

    // independent instruction writing rd, no sources
    task automatic dec_ind(input logic [4:0] rd);
        dec_valid = 1; dec_rs1_en = 0; dec_rs2_en = 0; dec_serial = 0;
        dec_rd = rd; dec_rd_we = 1;
    endtask

    task automatic ret(input logic [4:0] rd, input logic we);
        retire_valid = 1; retire_rd = rd; retire_we = we;
    endtask

    task automatic noret();
        retire_valid = 0; retire_we = 0; retire_rd = 0;
    endtask

    initial begin
        idle();
        // ---- reset with a valid instruction presented ----
        rst = 1; dec_valid = 1; dec_rd = 5; dec_rd_we = 1;
        #1 chk("rst_fire", issue_fire, 0);
        tick();
        chk("rst_cnt", inflight_cnt, 0);
        chk("rst_busy", busy_vec, 0);
        chk("rst_state", ctrl_state, 0);
        chk("rst_err", err, 0);
        rst = 0; idle();

        // ---- RAW: addi x5 ; add x6,x5,x1 ----
        dec_ind(5); dec_rs1_en = 1; dec_rs1 = 0;
        #1 chk("raw_addi_fire", issue_fire, 1);
        tick();
        chk("raw_busy5", busy_vec, 32'h20);
        chk("raw_cnt1", inflight_cnt, 1);
        dec_ind(6); dec_rs1 = 5; dec_rs2 = 1; dec_rs1_en = 1; dec_rs2_en = 1;
        #1 chk("raw_stall", dec_stall, 1);
        tick();
        chk("raw_stall2", dec_stall, 1);
        ret(5, 1);
        #1 chk("raw_same_cyc", issue_fire, 0);
        tick();
        noret();
        #1 chk("raw_next_fire", issue_fire, 1);
        chk("raw_busy_clr", busy_vec, 0);
        tick();
        chk("raw_busy6", busy_vec, 32'h40);
        idle(); ret(6, 1);
        tick();
        noret();
        chk("raw_cnt0", inflight_cnt, 0);

        // ---- cap at MAX_INFLIGHT ----
        for (int i = 0; i < 4; i++) begin
            dec_ind(5'(10 + i));
            #1 chk("cap_fire", issue_fire, 1);
            tick();
        end
        chk("cap_cnt4", inflight_cnt, 4);
        dec_ind(14);
        #1 chk("cap_5th_stall", dec_stall, 1);
        ret(10, 1);
        #1 chk("cap_ret_blocked", issue_fire, 0);
        tick();
        noret();
        chk("cap_cnt3", inflight_cnt, 3);
        #1 chk("cap_5th_fire", issue_fire, 1);
        tick();
        chk("cap_cnt_end", inflight_cnt, 4);
        chk("cap_busy", busy_vec, 32'h7800);
        idle();
        for (int i = 0; i < 4; i++) begin
            ret(5'(11 + i), 1);
            tick();
        end
        noret();
        chk("cap_drained", inflight_cnt, 0);
        chk("cap_busy0", busy_vec, 0);

        // ---- serializing csrrw ----
        dec_ind(20); tick();
        dec_ind(21); tick();
        chk("ser_cnt2", inflight_cnt, 2);
        dec_ind(22); dec_serial = 1;
        #1 chk("ser_wait", issue_fire, 0);
        tick();
        chk("ser_drain", ctrl_state, 1);
        ret(20, 1);
        #1 chk("ser_drain_fire0", issue_fire, 0);
        tick();
        ret(21, 1);
        #1 chk("ser_drain_fire1", issue_fire, 0);
        tick();
        noret();
        chk("ser_cnt0", inflight_cnt, 0);
        #1 chk("ser_issue", issue_fire, 1);
        tick();
        chk("ser_state_serial", ctrl_state, 2);
        chk("ser_busy22", busy_vec, 32'h0040_0000);
        dec_ind(7); dec_rs1 = 1; dec_rs2 = 2; dec_rs1_en = 1; dec_rs2_en = 1;
        #1 chk("ser_add_block", issue_fire, 0);
        tick();
        ret(22, 1);
        #1 chk("ser_add_block2", issue_fire, 0);
        tick();
        noret();
        chk("ser_state_idle", ctrl_state, 0);
        #1 chk("ser_add_fire", issue_fire, 1);
        tick();
        chk("ser_add_cnt", inflight_cnt, 1);
        idle(); ret(7, 1);
        tick();
        noret();

        // ---- flush ----
        dec_ind(8); flush = 1;
        #1 chk("flush_block", issue_fire, 0);
        flush = 0;
        dec_ind(9);
        tick();
        dec_ind(23); dec_serial = 1;
        #1 chk("flush_ser_wait", issue_fire, 0);
        tick();
        chk("flush_drain", ctrl_state, 1);
        flush = 1;
        #1 chk("flush_drain_fire", issue_fire, 0);
        tick();
        chk("flush_to_idle", ctrl_state, 0);
        chk("flush_cnt", inflight_cnt, 1);
        idle(); ret(9, 1);
        tick();
        noret();
        chk("flush_cnt0", inflight_cnt, 0);

        // ---- error / x0 ----
        chk("err_clean", err, 0);
        ret(0, 0);
        tick();
        noret();
        chk("err_set", err, 1);
        chk("err_cnt0", inflight_cnt, 0);
        tick();
        chk("err_sticky", err, 1);
        dec_ind(3);
        tick();
        chk("x3_busy", busy_vec, 32'h8);
        dec_ind(3);
        #1 chk("waw_block", issue_fire, 0);
        idle(); ret(0, 1);
        tick();
        noret();
        chk("x0_busy", busy_vec, 32'h8);

        // ---- reset mid-operation ----
        dec_ind(4);
        tick();
        chk("mid_cnt", inflight_cnt, 1);
        rst = 1;
        tick();
        rst = 0; idle();
        chk("mid_rst_cnt", inflight_cnt, 0);
        chk("mid_rst_busy", busy_vec, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_state", ctrl_state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
